// File: rtl/uart_proto_pkg.sv
// Shared protocol constants for the sensor UART link (host bridge and sensor controller).
package uart_proto_pkg;

   localparam logic [7:0]  HDR_M    = 8'h4D;
   localparam logic [7:0]  HDR_M_LC = 8'h6D;
   localparam logic [7:0]  HDR_A    = 8'h41;
   localparam logic [7:0]  HDR_A_LC = 8'h61;
   localparam logic [7:0]  OP_R     = 8'h52;
   localparam logic [7:0]  OP_S     = 8'h53;

   localparam int PAYLOAD_SHORT = 2;
   localparam int PAYLOAD_LONG  = 4;

   localparam logic [15:0] UART_CLKS_PER_BIT_DEF = 16'd2605;
   localparam logic [23:0] TIMEOUT_CLKS_DEF      = 24'd104200;

   typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT, T_NEXT} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_PAYLOAD, R_DONE} rx_state_t;

   // Number of bytes put on the wire for a command opcode; 0 means drop it.
   function automatic logic [1:0] cmd_bytes(input logic [7:0] op);
      case (op)
         OP_R, OP_S:         return 2'd1;
         HDR_M_LC, HDR_A_LC: return 2'd2;
         default:            return 2'd0;
      endcase
   endfunction

   // Payload length following a frame header; 0 marks an invalid header.
   function automatic logic [2:0] frame_payload(input logic [7:0] hdr);
      case (hdr)
         HDR_A:                     return 3'(PAYLOAD_LONG);
         HDR_M, HDR_M_LC, HDR_A_LC: return 3'(PAYLOAD_SHORT);
         default:                   return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/uart_host_rx_framer.sv
// Reassembles received bytes into 'A' (4-byte) and 'M'/'m'/'a' (2-byte) frames,
// with an inter-byte timeout and a saturating error counter.
module uart_host_rx_framer
   import uart_proto_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_RX_DV,
   input  logic [7:0]  i_RX_BYTE,
   output logic [39:0] o_FRAME,
   output logic        o_FRAME_VALID,
   output logic        o_FRAME_LONG,
   output logic [7:0]  o_ERR_COUNT
);
   rx_state_t   r_state;
   logic [39:0] r_shift;
   logic [39:0] r_frame;
   logic        r_valid;
   logic        r_long;
   logic [7:0]  r_err;
   logic [1:0]  r_idx;
   logic [1:0]  r_last;
   logic [23:0] r_tmo_cnt;
   logic [39:0] w_shift_next;
   logic [2:0]  w_hdr_len;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_hdr_len     = frame_payload(i_RX_BYTE);
   assign o_FRAME       = r_frame;
   assign o_FRAME_VALID = r_valid;
   assign o_FRAME_LONG  = r_long;
   assign o_ERR_COUNT   = r_err;

   always_comb begin
      w_shift_next = r_shift;
      case (r_idx)
         2'd0:    w_shift_next[31:24] = i_RX_BYTE;
         2'd1:    w_shift_next[23:16] = i_RX_BYTE;
         2'd2:    w_shift_next[15:8]  = i_RX_BYTE;
         default: w_shift_next[7:0]   = i_RX_BYTE;
      endcase
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_state   <= R_IDLE;
         r_shift   <= '0;
         r_frame   <= '0;
         r_valid   <= 1'b0;
         r_long    <= 1'b0;
         r_err     <= '0;
         r_idx     <= '0;
         r_last    <= '0;
         r_tmo_cnt <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            R_IDLE: begin
               r_tmo_cnt <= '0;
               if (i_RX_DV) begin
                  if (w_hdr_len == 3'd0) begin
                     r_err <= sat_inc(r_err);
                  end else begin
                     r_shift <= {i_RX_BYTE, 32'h0};
                     r_idx   <= 2'd0;
                     r_last  <= 2'(w_hdr_len - 3'd1);
                     r_state <= R_PAYLOAD;
                  end
               end
            end
            // A byte arriving on the expiry cycle still counts; only silence drops the frame.
            R_PAYLOAD: begin
               if (i_RX_DV) begin
                  r_tmo_cnt <= '0;
                  r_shift   <= w_shift_next;
                  r_idx     <= r_idx + 2'd1;
                  if (r_idx == r_last) begin
                     r_frame <= w_shift_next;
                     r_long  <= (r_shift[39:32] == HDR_A);
                     r_valid <= 1'b1;
                     r_state <= R_DONE;
                  end
               end else if (r_tmo_cnt == TIMEOUT_CLKS) begin
                  r_tmo_cnt <= '0;
                  r_err     <= sat_inc(r_err);
                  r_state   <= R_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 24'd1;
               end
            end
            R_DONE:  r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver core; samples each bit at its centre and pulses o_Rx_DV on a valid stop bit.
module uart_rx #(
   parameter logic [15:0] CLKS_PER_BIT = 16'd2605
) (
   input  logic       i_Clock,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_byte;
   logic        r_dv;
   logic        r_low_meta;
   logic        r_low;
   logic        w_bit_end;

   assign w_bit_end = (r_cnt == CLKS_PER_BIT - 16'd1);
   assign o_Rx_DV   = r_dv;
   assign o_Rx_Byte = r_byte;

   // Synchronizer holds the inverted line so the zero power-up value reads as idle.
   always_ff @(posedge i_Clock) begin
      r_low_meta <= ~i_Rx_Serial;
      r_low      <= r_low_meta;
      r_dv       <= 1'b0;
      r_cnt      <= w_bit_end ? 16'd0 : r_cnt + 16'd1;
      case (r_state)
         S_IDLE: begin
            r_cnt <= 16'd0;
            r_bit <= 3'd0;
            if (r_low) r_state <= S_START;
         end
         S_START: if (r_cnt == ((CLKS_PER_BIT - 16'd1) >> 1)) begin
            r_cnt   <= 16'd0;
            r_state <= r_low ? S_DATA : S_IDLE;
         end
         S_DATA: if (w_bit_end) begin
            r_byte[r_bit] <= ~r_low;
            r_bit         <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
         end
         S_STOP: if (w_bit_end) begin
            r_dv    <= ~r_low;
            r_state <= S_IDLE;
         end
         default: r_state <= S_IDLE;
      endcase
   end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter core; no reset, the all-zero power-up state is idle with the line high.
module uart_tx #(
   parameter logic [15:0] CLKS_PER_BIT = 16'd2605
) (
   input  logic       i_Clock,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_data;
   logic        r_done;
   logic        w_bit_end;

   assign w_bit_end = (r_cnt == CLKS_PER_BIT - 16'd1);
   assign o_Tx_Done = r_done;

   always_comb begin
      case (r_state)
         S_START: o_Tx_Serial = 1'b0;
         S_DATA:  o_Tx_Serial = r_data[r_bit];
         default: o_Tx_Serial = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      r_done <= 1'b0;
      r_cnt  <= w_bit_end ? 16'd0 : r_cnt + 16'd1;
      case (r_state)
         S_IDLE: begin
            r_cnt <= 16'd0;
            r_bit <= 3'd0;
            if (i_Tx_DV) begin
               r_data  <= i_Tx_Byte;
               r_state <= S_START;
            end
         end
         S_START: if (w_bit_end) r_state <= S_DATA;
         S_DATA: if (w_bit_end) begin
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
         end
         S_STOP: if (w_bit_end) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
         end
         default: r_state <= S_IDLE;
      endcase
   end
endmodule

// File: rtl/uart_host_bridge.sv
// Host-side endpoint of the sensor UART link: serializes host commands onto TXD
// and hands complete sensor frames from RXD to the host as parallel words.
module uart_host_bridge
   import uart_proto_pkg::*;
#(
   parameter logic [15:0] UART_CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter logic [23:0] TIMEOUT_CLKS      = TIMEOUT_CLKS_DEF
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_UART_RXD,
   output logic        o_UART_TXD,
   input  logic [15:0] i_CMD,
   input  logic        i_CMD_VALID,
   output logic        o_CMD_READY,
   output logic [39:0] o_FRAME,
   output logic        o_FRAME_VALID,
   output logic        o_FRAME_LONG,
   output logic [7:0]  o_ERR_COUNT
);
   tx_state_t   r_tx_state;
   logic [15:0] r_cmd;
   logic [1:0]  r_left;
   logic        r_cmd_ready;
   logic        r_tx_dv;
   logic        w_tx_done;
   logic        w_rx_dv;
   logic [7:0]  w_rx_byte;
   logic [1:0]  w_cmd_len;

   assign w_cmd_len   = cmd_bytes(i_CMD[15:8]);
   assign o_CMD_READY = r_cmd_ready;

   // The byte on the wire is always r_cmd[15:8]; T_NEXT shifts the address up.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_tx_state  <= T_IDLE;
         r_cmd       <= '0;
         r_left      <= '0;
         r_cmd_ready <= 1'b0;
         r_tx_dv     <= 1'b0;
      end else begin
         case (r_tx_state)
            T_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (i_CMD_VALID && r_cmd_ready) begin
                  r_cmd       <= i_CMD;
                  r_left      <= w_cmd_len;
                  r_tx_dv     <= (w_cmd_len != 2'd0);
                  r_cmd_ready <= 1'b0;
                  r_tx_state  <= T_LOAD;
               end
            end
            T_LOAD: begin
               r_tx_dv    <= 1'b0;
               r_tx_state <= (r_left == 2'd0) ? T_IDLE : T_WAIT;
            end
            T_WAIT: if (w_tx_done) r_tx_state <= T_NEXT;
            T_NEXT: begin
               r_cmd  <= {r_cmd[7:0], 8'h00};
               r_left <= r_left - 2'd1;
               if (r_left == 2'd1) begin
                  r_cmd_ready <= 1'b1;
                  r_tx_state  <= T_IDLE;
               end else begin
                  r_tx_dv    <= 1'b1;
                  r_tx_state <= T_LOAD;
               end
            end
            default: r_tx_state <= T_IDLE;
         endcase
      end
   end

   uart_tx #(.CLKS_PER_BIT(UART_CLKS_PER_BIT)) u_tx (
      .i_Clock     (i_CLK),
      .i_Tx_DV     (r_tx_dv),
      .i_Tx_Byte   (r_cmd[15:8]),
      .o_Tx_Serial (o_UART_TXD),
      .o_Tx_Done   (w_tx_done)
   );

   uart_rx #(.CLKS_PER_BIT(UART_CLKS_PER_BIT)) u_rx (
      .i_Clock     (i_CLK),
      .i_Rx_Serial (i_UART_RXD),
      .o_Rx_DV     (w_rx_dv),
      .o_Rx_Byte   (w_rx_byte)
   );

   uart_host_rx_framer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_framer (
      .i_CLK         (i_CLK),
      .i_RST         (i_RST),
      .i_RX_DV       (w_rx_dv),
      .i_RX_BYTE     (w_rx_byte),
      .o_FRAME       (o_FRAME),
      .o_FRAME_VALID (o_FRAME_VALID),
      .o_FRAME_LONG  (o_FRAME_LONG),
      .o_ERR_COUNT   (o_ERR_COUNT)
   );
endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: serial byte and frame scoreboards plus handshake timing checks.
module tb_uart_host_bridge;
   localparam int CPB = 10;
   localparam int TMO = 500;

   logic        i_CLK;
   logic        i_RST;
   logic        i_UART_RXD;
   logic        o_UART_TXD;
   logic [15:0] i_CMD;
   logic        i_CMD_VALID;
   logic        o_CMD_READY;
   logic [39:0] o_FRAME;
   logic        o_FRAME_VALID;
   logic        o_FRAME_LONG;
   logic [7:0]  o_ERR_COUNT;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  tx_q[$];
   logic [40:0] frm_q[$];

   uart_host_bridge #(
      .UART_CLKS_PER_BIT (16'(CPB)),
      .TIMEOUT_CLKS      (24'(TMO))
   ) dut (
      .i_CLK         (i_CLK),
      .i_RST         (i_RST),
      .i_UART_RXD    (i_UART_RXD),
      .o_UART_TXD    (o_UART_TXD),
      .i_CMD         (i_CMD),
      .i_CMD_VALID   (i_CMD_VALID),
      .o_CMD_READY   (o_CMD_READY),
      .o_FRAME       (o_FRAME),
      .o_FRAME_VALID (o_FRAME_VALID),
      .o_FRAME_LONG  (o_FRAME_LONG),
      .o_ERR_COUNT   (o_ERR_COUNT)
   );

   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_len(input logic [7:0] op);
      if (op == 8'h52 || op == 8'h53) return 1;
      if (op == 8'h6D || op == 8'h61) return 2;
      return 0;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         i_UART_RXD = f[i];
         repeat (CPB) @(negedge i_CLK);
      end
   endtask

   task automatic issue_cmd(input logic [15:0] cmd);
      int t;
      int n;
      t = 0;
      n = model_len(cmd[15:8]);
      while (!o_CMD_READY && t < 2000) begin
         @(negedge i_CLK);
         t++;
      end
      check("cmd_ready_wait", 64'(o_CMD_READY), 64'(1));
      if (n >= 1) tx_q.push_back(cmd[15:8]);
      if (n == 2) tx_q.push_back(cmd[7:0]);
      i_CMD       = cmd;
      i_CMD_VALID = 1'b1;
      @(negedge i_CLK);
      i_CMD_VALID = 1'b0;
      check("cmd_ready_fall", 64'(o_CMD_READY), 64'(0));
      if (n > 0) begin
         @(negedge i_CLK);
         check("txd_start_latency", 64'(o_UART_TXD), 64'(0));
      end
   endtask

   task automatic wait_ready_after_done(input int ndone);
      int t;
      int seen;
      int lag;
      t = 0;
      seen = 0;
      lag = 0;
      while (seen < ndone && t < 40 * CPB) begin
         @(negedge i_CLK);
         t++;
         if (dut.w_tx_done) seen++;
      end
      check("tx_done_count", 64'(seen), 64'(ndone));
      while (!o_CMD_READY && lag < 5) begin
         @(negedge i_CLK);
         lag++;
      end
      check("ready_after_done_le2", 64'(lag <= 2), 64'(1));
   endtask

   // Serial decoder for the bridge's TXD, checked against the command scoreboard.
   initial begin : tx_monitor
      logic [7:0] b;
      forever begin
         @(negedge i_CLK);
         if (o_UART_TXD == 1'b0) begin
            repeat (CPB / 2) @(negedge i_CLK);
            check("tx_start_bit", 64'(o_UART_TXD), 64'(0));
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge i_CLK);
               b[i] = o_UART_TXD;
            end
            repeat (CPB) @(negedge i_CLK);
            check("tx_stop_bit", 64'(o_UART_TXD), 64'(1));
            check("tx_byte_expected", 64'(tx_q.size() > 0), 64'(1));
            if (tx_q.size() > 0) check("tx_byte", 64'(b), 64'(tx_q.pop_front()));
         end
      end
   end

   initial begin : frame_monitor
      logic        prev_dv;
      logic [40:0] exp_f;
      prev_dv = 1'b0;
      forever begin
         @(negedge i_CLK);
         if (o_FRAME_VALID) begin
            check("frame_after_rx_dv", 64'(prev_dv), 64'(1));
            check("frame_expected", 64'(frm_q.size() > 0), 64'(1));
            if (frm_q.size() > 0) begin
               exp_f = frm_q.pop_front();
               check("frame_data", 64'(o_FRAME), 64'(exp_f[39:0]));
               check("frame_long", 64'(o_FRAME_LONG), 64'(exp_f[40]));
            end
            @(negedge i_CLK);
            check("frame_valid_width", 64'(o_FRAME_VALID), 64'(0));
         end
         prev_dv = dut.w_rx_dv;
      end
   end

   initial begin : stimulus
      int t;
      int busy;
      i_RST       = 1'b1;
      i_UART_RXD  = 1'b1;
      i_CMD       = 16'h0000;
      i_CMD_VALID = 1'b0;
      repeat (3) @(negedge i_CLK);
      check("rst_cmd_ready", 64'(o_CMD_READY), 64'(0));
      check("rst_frame", 64'(o_FRAME), 64'(0));
      check("rst_frame_valid", 64'(o_FRAME_VALID), 64'(0));
      check("rst_frame_long", 64'(o_FRAME_LONG), 64'(0));
      check("rst_err_count", 64'(o_ERR_COUNT), 64'(0));
      i_RST = 1'b0;
      @(negedge i_CLK);
      check("ready_after_release", 64'(o_CMD_READY), 64'(1));

      // Single-byte command
      issue_cmd(16'h5200);
      wait_ready_after_done(1);

      // Two-byte command with a second request held through the transfer
      issue_cmd(16'h6D1F);
      tx_q.push_back(8'h53);
      i_CMD       = 16'h5300;
      i_CMD_VALID = 1'b1;
      busy = 0;
      while (!o_CMD_READY && busy < 40 * CPB) begin
         @(negedge i_CLK);
         busy++;
      end
      check("held_cmd_waits", 64'(busy >= 19 * CPB), 64'(1));
      @(negedge i_CLK);
      i_CMD_VALID = 1'b0;
      check("held_cmd_accepted", 64'(o_CMD_READY), 64'(0));
      wait_ready_after_done(1);

      // Unknown opcode is consumed silently
      issue_cmd(16'h7700);
      t = 0;
      while (!o_CMD_READY && t < 10) begin
         @(negedge i_CLK);
         t++;
      end
      check("bad_op_ready_back", 64'(t <= 2), 64'(1));
      check("bad_op_err_unchanged", 64'(o_ERR_COUNT), 64'(0));

      // Long frame
      frm_q.push_back({1'b1, 40'h4112345678});
      send_byte(8'h41); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      repeat (5) @(negedge i_CLK);
      check("frame_hold_long", 64'(o_FRAME), 64'(40'h4112345678));

      // Short frame then a stray byte
      frm_q.push_back({1'b0, 40'h4DABCD0000});
      send_byte(8'h4D); send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h7E);
      repeat (2) @(negedge i_CLK);
      check("stray_err", 64'(o_ERR_COUNT), 64'(1));

      // Truncated frame resolved by timeout
      send_byte(8'h41); send_byte(8'h01); send_byte(8'h02);
      repeat (TMO + 200) @(negedge i_CLK);
      check("timeout_err", 64'(o_ERR_COUNT), 64'(2));
      check("timeout_frame_hold", 64'(o_FRAME), 64'(40'h4DABCD0000));
      check("timeout_long_hold", 64'(o_FRAME_LONG), 64'(0));

      frm_q.push_back({1'b0, 40'h6105A00000});
      send_byte(8'h61); send_byte(8'h05); send_byte(8'hA0);
      repeat (5) @(negedge i_CLK);

      // Full duplex: command out while a frame comes in
      fork
         begin
            issue_cmd(16'h6142);
            wait_ready_after_done(2);
         end
         begin
            frm_q.push_back({1'b0, 40'h4D55660000});
            send_byte(8'h4D); send_byte(8'h55); send_byte(8'h66);
         end
      join
      repeat (5) @(negedge i_CLK);
      check("duplex_err", 64'(o_ERR_COUNT), 64'(2));

      // Error counter saturation
      for (int i = 0; i < 253; i++) send_byte(8'h7E);
      repeat (2) @(negedge i_CLK);
      check("err_reaches_ff", 64'(o_ERR_COUNT), 64'(8'hFF));
      send_byte(8'h7E); send_byte(8'h00);
      repeat (2) @(negedge i_CLK);
      check("err_saturated", 64'(o_ERR_COUNT), 64'(8'hFF));

      // Reset in the middle of a long frame
      send_byte(8'h41); send_byte(8'hAA);
      i_RST = 1'b1;
      @(negedge i_CLK);
      check("midrst_cmd_ready", 64'(o_CMD_READY), 64'(0));
      check("midrst_frame", 64'(o_FRAME), 64'(0));
      check("midrst_frame_valid", 64'(o_FRAME_VALID), 64'(0));
      check("midrst_frame_long", 64'(o_FRAME_LONG), 64'(0));
      check("midrst_err", 64'(o_ERR_COUNT), 64'(0));
      repeat (3) @(negedge i_CLK);
      i_RST = 1'b0;
      @(negedge i_CLK);
      check("midrst_ready_back", 64'(o_CMD_READY), 64'(1));

      frm_q.push_back({1'b0, 40'h4D11220000});
      send_byte(8'h4D); send_byte(8'h11); send_byte(8'h22);
      repeat (50) @(negedge i_CLK);
      check("post_rst_frame_hold", 64'(o_FRAME), 64'(40'h4D11220000));
      check("post_rst_err", 64'(o_ERR_COUNT), 64'(0));
      check("tx_queue_drained", 64'(tx_q.size()), 64'(0));
      check("frame_queue_drained", 64'(frm_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
